// File: rtl/fxp_mult_seq.sv
// Sequential signed fixed-point multiplier: sign-magnitude shift-add, one multiplier bit per cycle.
// Result valid WIDTH+1 edges after the accepting edge; holds in DONE until out_ready.
module fxp_mult_seq #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 11,
  parameter int ROUND    = 0,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] product,
  output logic             overflow,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH + 1;
  localparam logic signed [PW-1:0] RND =
    (ROUND != 0 && FRAC > 0) ? (PW'(1) << ((FRAC > 0) ? FRAC - 1 : 0)) : '0;
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    FINISH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sign_q, sign_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH-1:0]   prod_q, prod_d;
  logic               ovf_q, ovf_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic signed [PW-1:0] full, rounded, shifted;
  logic [PW-WIDTH:0]  hi;
  logic               out_of_range;

  // Unsigned magnitudes: the most negative input maps to 2^(WIDTH-1) without loss.
  assign abs_a = a[WIDTH-1] ? (~a) + WIDTH'(1) : a;
  assign abs_b = b[WIDTH-1] ? (~b) + WIDTH'(1) : b;

  assign full         = sign_q ? -$signed({1'b0, acc_q}) : $signed({1'b0, acc_q});
  assign rounded      = full + RND;
  assign shifted      = rounded >>> FRAC;
  assign hi           = shifted[PW-1:WIDTH-1];
  assign out_of_range = !((&hi) || (~|hi));

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = a[WIDTH-1] ^ b[WIDTH-1];
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mplier_q[0]) acc_d = acc_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FINISH;
      end
      FINISH: begin
        ovf_d = out_of_range;
        if (out_of_range && SATURATE != 0) prod_d = shifted[PW-1] ? MINV : MAXV;
        else                               prod_d = shifted[WIDTH-1:0];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = prod_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_fxp_mult_seq.sv
// Bench for fxp_mult_seq: four 16/11 instances (every ROUND/SATURATE pair) plus 8/4 and 24/16 instances,
// checked against fixed vectors and a plain-arithmetic reference model.
module tb_fxp_mult_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // group 0: WIDTH=16 FRAC=11, instance k has ROUND=k/2, SATURATE=k%2
  logic        iv16 = 1'b0, or16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        rdy16[4], ov16[4], of16[4], bz16[4];
  logic [15:0] p16[4];

  for (genvar g = 0; g < 4; g++) begin : g16
    fxp_mult_seq #(.WIDTH(16), .FRAC(11), .ROUND(g / 2), .SATURATE(g % 2)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(rdy16[g]), .a(a16), .b(b16),
      .out_valid(ov16[g]), .out_ready(or16), .product(p16[g]), .overflow(of16[g]), .busy(bz16[g]));
  end

  // group 1: WIDTH=8 FRAC=4 ROUND=1 SATURATE=1
  logic       iv8 = 1'b0, or8 = 1'b0, rdy8, ov8, of8, bz8;
  logic [7:0] a8 = '0, b8 = '0, p8;
  fxp_mult_seq #(.WIDTH(8), .FRAC(4), .ROUND(1), .SATURATE(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .product(p8), .overflow(of8), .busy(bz8));

  // group 2: WIDTH=24 FRAC=16 ROUND=0 SATURATE=0
  logic        iv24 = 1'b0, or24 = 1'b0, rdy24, ov24, of24, bz24;
  logic [23:0] a24 = '0, b24 = '0, p24;
  fxp_mult_seq #(.WIDTH(24), .FRAC(16), .ROUND(0), .SATURATE(0)) dut24 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv24), .in_ready(rdy24), .a(a24), .b(b24),
    .out_valid(ov24), .out_ready(or24), .product(p24), .overflow(of24), .busy(bz24));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: exact signed product, optional +half LSB, floor shift, then clamp or wrap.
  function automatic logic [31:0] ref_mul(input int w, input int f, input int rnd, input int sat,
                                          input logic [31:0] av, input logic [31:0] bv,
                                          output logic ovf);
    longint sa, sb, p, s, mx, mn;
    sa = longint'($signed(av << (32 - w))) >>> (32 - w);
    sb = longint'($signed(bv << (32 - w))) >>> (32 - w);
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    p  = sa * sb;
    if (rnd != 0 && f > 0) p += longint'(1) << (f - 1);
    s   = p >>> f;
    ovf = (s > mx) || (s < mn);
    if (sat != 0 && ovf) s = (s > 0) ? mx : mn;
    return 32'(s & ((longint'(1) << w) - 1));
  endfunction

  function automatic int gw(input int g);
    return (g == 0) ? 16 : (g == 1) ? 8 : 24;
  endfunction

  function automatic logic ovalid(input int g);
    return (g == 0) ? ov16[0] : (g == 1) ? ov8 : ov24;
  endfunction

  function automatic logic irdy(input int g);
    return (g == 0) ? rdy16[0] : (g == 1) ? rdy8 : rdy24;
  endfunction

  task automatic drive(input int g, input logic iv, input logic [31:0] av, input logic [31:0] bv);
    case (g)
      0:       begin iv16 = iv; a16 = av[15:0]; b16 = bv[15:0]; end
      1:       begin iv8  = iv; a8  = av[7:0];  b8  = bv[7:0];  end
      default: begin iv24 = iv; a24 = av[23:0]; b24 = bv[23:0]; end
    endcase
  endtask

  task automatic set_or(input int g, input logic v);
    case (g)
      0:       or16 = v;
      1:       or8  = v;
      default: or24 = v;
    endcase
  endtask

  // Called at a negedge with the group idle; returns at the negedge where out_valid is first seen.
  // Operands are scrambled and in_valid kept high while busy: none of it may matter.
  task automatic start(input int g, input logic [31:0] av, input logic [31:0] bv, input string nm);
    int k;
    chk({nm, " in_ready"}, irdy(g), 1'b1);
    drive(g, 1'b1, av, bv);
    @(posedge clk);
    @(negedge clk);
    drive(g, 1'b1, $urandom, $urandom);
    k = 0;
    while (!ovalid(g) && k < 100) begin
      @(posedge clk);
      @(negedge clk);
      k++;
      if (k == 5) drive(g, 1'b1, $urandom, $urandom);
    end
    drive(g, 1'b0, $urandom, $urandom);
    // Accept edge, WIDTH BUSY edges, FINISH edge: edge WIDTH+2 counting the accept itself.
    chk({nm, " latency"}, k, gw(g) + 1);
    if (g == 0)
      for (int j = 1; j < 4; j++) chk({nm, " out_valid"}, ov16[j], 1'b1);
  endtask

  task automatic release_out(input int g, input string nm);
    set_or(g, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_or(g, 1'b0);
    chk({nm, " out_valid drop"}, ovalid(g), 1'b0);
    chk({nm, " back to idle"}, irdy(g), 1'b1);
  endtask

  task automatic check_model(input int g, input logic [31:0] av, input logic [31:0] bv,
                             input string nm);
    logic [31:0] ep;
    logic        eo;
    if (g == 0) begin
      for (int k = 0; k < 4; k++) begin
        ep = ref_mul(16, 11, k / 2, k % 2, av, bv, eo);
        chk({nm, " product16"}, p16[k], ep);
        chk({nm, " overflow16"}, of16[k], eo);
      end
    end else if (g == 1) begin
      ep = ref_mul(8, 4, 1, 1, av, bv, eo);
      chk({nm, " product8"}, p8, ep);
      chk({nm, " overflow8"}, of8, eo);
    end else begin
      ep = ref_mul(24, 16, 0, 0, av, bv, eo);
      chk({nm, " product24"}, p24, ep);
      chk({nm, " overflow24"}, of24, eo);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          cfg;   // {ROUND,SATURATE} of the instance being checked
    logic [15:0] p;
    logic        o;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int seen, c, r0, r1;
    logic prev;
    logic [31:0] av, bv;

    tbl[0]  = '{16'h0800, 16'h0800, 1, 16'h0800, 1'b0};
    tbl[1]  = '{16'h0C00, 16'hF000, 1, 16'hE800, 1'b0};
    tbl[2]  = '{16'h7FFF, 16'h7FFF, 1, 16'h7FFF, 1'b1};
    tbl[3]  = '{16'h7FFF, 16'h7FFF, 0, 16'hFFE0, 1'b1};
    tbl[4]  = '{16'h8000, 16'h8000, 1, 16'h7FFF, 1'b1};
    tbl[5]  = '{16'h0001, 16'h0400, 0, 16'h0000, 1'b0};
    tbl[6]  = '{16'h0001, 16'h0400, 2, 16'h0001, 1'b0};
    tbl[7]  = '{16'hFFFF, 16'h0400, 0, 16'hFFFF, 1'b0};
    tbl[8]  = '{16'hFFFF, 16'h0400, 2, 16'h0000, 1'b0};
    tbl[9]  = '{16'h8000, 16'h7FFF, 1, 16'h8000, 1'b1};
    tbl[10] = '{16'h8000, 16'h7FFF, 0, 16'h0010, 1'b1};

    #2 rst_n = 1'b0;
    #1;
    chk("reset in_ready", rdy16[1], 1'b1);
    chk("reset out_valid", ov16[1], 1'b0);
    chk("reset busy", bz16[1], 1'b0);
    chk("reset product", p16[1], 16'h0);
    chk("reset overflow", of16[1], 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // First vector accepts on the very first edge after reset release.
    for (int i = 0; i < 11; i++) begin
      start(0, {16'h0, tbl[i].a}, {16'h0, tbl[i].b}, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d product", i), p16[tbl[i].cfg], tbl[i].p);
      chk($sformatf("vec%0d overflow", i), of16[tbl[i].cfg], tbl[i].o);
      release_out(0, $sformatf("vec%0d", i));
    end

    // Result held in DONE with out_ready low while in_valid toggles.
    start(0, 32'h0C00, 32'hF000, "hold");
    for (int i = 0; i < 10; i++) begin
      drive(0, 1'(i % 2), $urandom, $urandom);
      @(posedge clk);
      @(negedge clk);
      chk("hold out_valid", ov16[1], 1'b1);
      chk("hold product", p16[1], 16'hE800);
      chk("hold overflow", of16[1], 1'b0);
      chk("hold in_ready", rdy16[1], 1'b0);
      chk("hold busy", bz16[1], 1'b1);
    end
    drive(0, 1'b0, 32'h0, 32'h0);
    release_out(0, "hold");

    // Reset during the fifth BUSY cycle discards the operation.
    drive(0, 1'b1, 32'h7FFF, 32'h7FFF);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1'b0, 32'h0, 32'h0);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("midreset busy", bz16[k], 1'b0);
      chk("midreset out_valid", ov16[k], 1'b0);
      chk("midreset in_ready", rdy16[k], 1'b1);
      chk("midreset product", p16[k], 16'h0);
      chk("midreset overflow", of16[k], 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ov16[0] || ov16[1] || ov16[2] || ov16[3] || bz16[0]) seen++;
    end
    chk("no result after reset", seen, 0);

    // Back-to-back with in_valid and out_ready held: one result per WIDTH+3 cycles.
    drive(0, 1'b1, 32'h0800, 32'h0800);
    set_or(0, 1'b1);
    prev = 1'b0; seen = 0; r0 = 0; r1 = 0; c = 0;
    while (seen < 2 && c < 200) begin
      @(negedge clk);
      c++;
      if (ov16[0] && !prev) begin
        if (seen == 0) r0 = c; else r1 = c;
        seen++;
      end
      prev = ov16[0];
    end
    drive(0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    set_or(0, 1'b0);
    chk("throughput results", seen, 2);
    chk("throughput spacing", r1 - r0, 19);
    chk("throughput idle", rdy16[0], 1'b1);

    // Random operands with occasional most-negative values.
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 30; i++) begin
        av = $urandom;
        bv = $urandom;
        if ($urandom_range(0, 7) == 0) av = 32'(1) << (gw(g) - 1);
        if ($urandom_range(0, 7) == 0) bv = 32'(1) << (gw(g) - 1);
        av = av & ((32'(1) << gw(g)) - 1);
        bv = bv & ((32'(1) << gw(g)) - 1);
        start(g, av, bv, $sformatf("rand g%0d #%0d", g, i));
        check_model(g, av, bv, $sformatf("rand g%0d #%0d", g, i));
        release_out(g, $sformatf("rand g%0d #%0d", g, i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
